// File: rtl/bp_pkg.sv
// Shared definitions for the branch-history-table update path:
// 2-bit counter encodings, controller state codes and the saturating counter step.
package bp_pkg;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  localparam logic [1:0] ST_INIT  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_FLUSH = 2'b10;

  // One step toward the actual outcome, clamped at both ends (no wrap).
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    case (cnt)
      CNT_SNT: res = taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: res = taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  res = taken ? CNT_ST  : CNT_WNT;
      CNT_ST:  res = taken ? CNT_ST  : CNT_WT;
      default: res = CNT_SNT;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Small synchronous FIFO holding resolved-branch updates; pointers carry an
// extra wrap bit so full and empty are distinguishable without a counter.
module bp_upd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointer update; clear wins over any push/pop in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
    end else if (i_clr) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Entry storage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= {WIDTH{1'b0}};
    end else if (w_do_push && !i_clr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/bht_update_ctrl.sv
// Owner of the BHT write port: sweeps the table to strongly-not-taken after reset
// or flush, then applies queued branch outcomes as saturating read-modify-writes.
module bht_update_ctrl
  import bp_pkg::*;
#(
  parameter int N          = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         upd_valid_i,
  input  logic [31:0]  upd_pc_i,
  input  logic         upd_taken_i,
  output logic         upd_ready_o,
  input  logic         flush_i,
  output logic [N-1:0] tbl_rd_addr_o,
  input  logic [1:0]   tbl_rd_data_i,
  output logic         tbl_we_o,
  output logic [N-1:0] tbl_wr_addr_o,
  output logic [1:0]   tbl_wr_data_o,
  output logic         pred_enable_o,
  output logic         busy_o
);

  localparam int          EW       = N + 1;
  localparam logic [N-1:0] LAST_IDX = {N{1'b1}};
  localparam logic [N-1:0] IDX_ONE  = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [N-1:0]  r_sweep_cnt;
  logic [N-1:0]  w_sweep_nxt;
  logic          r_pred_en;
  logic          w_sweeping;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [EW-1:0] w_head;
  logic [EW-1:0] w_push_data;
  logic          w_unused_pc;

  assign w_unused_pc = ^{upd_pc_i[31:N+2], upd_pc_i[1:0]};

  assign w_sweeping  = (r_state != ST_RUN);
  // Ready is forced low in reset so nothing is accepted while the FIFO is held clear.
  assign upd_ready_o = rst_i && !w_full && !flush_i;
  assign w_push      = upd_valid_i && upd_ready_o;
  assign w_pop       = rst_i && !w_sweeping && !w_empty && !flush_i;
  assign w_push_data = {upd_pc_i[N+1:2], upd_taken_i};

  bp_upd_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_clr   (flush_i),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Next state and sweep index; a flush restarts the sweep from any state.
  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep_cnt;
    if (flush_i) begin
      w_state_nxt = ST_FLUSH;
      w_sweep_nxt = {N{1'b0}};
    end else begin
      case (r_state)
        ST_INIT, ST_FLUSH: begin
          if (r_sweep_cnt == LAST_IDX) begin
            w_state_nxt = ST_RUN;
            w_sweep_nxt = {N{1'b0}};
          end else begin
            w_sweep_nxt = r_sweep_cnt + IDX_ONE;
          end
        end
        ST_RUN: begin
          w_state_nxt = ST_RUN;
          w_sweep_nxt = {N{1'b0}};
        end
        default: begin
          w_state_nxt = ST_INIT;
          w_sweep_nxt = {N{1'b0}};
        end
      endcase
    end
  end

  // Table write port: sweep clear, or RMW of the FIFO head against same-cycle read data.
  always_comb begin
    tbl_we_o      = 1'b0;
    tbl_wr_addr_o = {N{1'b0}};
    tbl_wr_data_o = CNT_SNT;
    tbl_rd_addr_o = w_head[EW-1:1];
    if (!rst_i) begin
      tbl_we_o = 1'b0;
    end else if (w_sweeping) begin
      tbl_we_o      = 1'b1;
      tbl_wr_addr_o = r_sweep_cnt;
      tbl_wr_data_o = CNT_SNT;
    end else if (w_pop) begin
      tbl_we_o      = 1'b1;
      tbl_wr_addr_o = w_head[EW-1:1];
      tbl_wr_data_o = sat_update(tbl_rd_data_i, w_head[0]);
    end else begin
      tbl_we_o = 1'b0;
    end
  end

  // State, sweep counter and registered prediction-enable decode.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= ST_INIT;
      r_sweep_cnt <= {N{1'b0}};
      r_pred_en   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_cnt <= w_sweep_nxt;
      r_pred_en   <= (w_state_nxt == ST_RUN);
    end
  end

  assign pred_enable_o = r_pred_en;
  assign busy_o        = w_sweeping || !w_empty;

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Directed bench for bht_update_ctrl with N=4, FIFO_DEPTH=4 and a behavioural BHT array.
module tb_bht_update_ctrl;

  localparam int N = 4;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         upd_valid_i = 1'b0;
  logic [31:0]  upd_pc_i = 32'h0;
  logic         upd_taken_i = 1'b0;
  logic         upd_ready_o;
  logic         flush_i = 1'b0;
  logic [N-1:0] tbl_rd_addr_o;
  logic [1:0]   tbl_rd_data_i;
  logic         tbl_we_o;
  logic [N-1:0] tbl_wr_addr_o;
  logic [1:0]   tbl_wr_data_o;
  logic         pred_enable_o;
  logic         busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  int nz_writes = 0;
  int nz_snap;

  logic [1:0] bht [16];

  bht_update_ctrl #(.N(N), .FIFO_DEPTH(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .upd_taken_i   (upd_taken_i),
    .upd_ready_o   (upd_ready_o),
    .flush_i       (flush_i),
    .tbl_rd_addr_o (tbl_rd_addr_o),
    .tbl_rd_data_i (tbl_rd_data_i),
    .tbl_we_o      (tbl_we_o),
    .tbl_wr_addr_o (tbl_wr_addr_o),
    .tbl_wr_data_o (tbl_wr_data_o),
    .pred_enable_o (pred_enable_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  assign tbl_rd_data_i = bht[tbl_rd_addr_o];

  always @(posedge clk_i) begin
    if (tbl_we_o) begin
      bht[tbl_wr_addr_o] <= tbl_wr_data_o;
      if (tbl_wr_data_o != 2'b00) nz_writes <= nz_writes + 1;
    end
  end

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        taken;
    logic        exp_we;
    logic [1:0]  exp_data;
    logic        exp_ready;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    upd_valid_i = 1'b0;
    flush_i     = 1'b0;
  endtask

  task automatic do_sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      idle_inputs();
      #1;
      chk({tag, "_we"}, tbl_we_o, 1'b1);
      chk({tag, "_addr"}, tbl_wr_addr_o, i);
      chk({tag, "_data"}, tbl_wr_data_o, 2'b00);
      chk({tag, "_pred"}, pred_enable_o, 1'b0);
      chk({tag, "_busy"}, busy_o, 1'b1);
    end
    @(negedge clk_i);
    #1;
    chk({tag, "_pred_up"}, pred_enable_o, 1'b1);
    chk({tag, "_busy_dn"}, busy_o, 1'b0);
    chk({tag, "_we_idle"}, tbl_we_o, 1'b0);
  endtask

  task automatic put_upd(input logic [31:0] pc, input logic taken);
    upd_valid_i = 1'b1;
    upd_pc_i    = pc;
    upd_taken_i = taken;
  endtask

  logic [31:0] fpc [5];
  logic        ftk [5];

  initial begin
    // Saturation walk on index 2; each row's expected write is for the update pushed one row earlier.
    vecs[0] = '{1'b1, 32'h0000_0008, 1'b1, 1'b0, 2'b00, 1'b1};
    vecs[1] = '{1'b1, 32'h0000_0008, 1'b1, 1'b1, 2'b01, 1'b1};
    vecs[2] = '{1'b1, 32'h0000_0008, 1'b1, 1'b1, 2'b10, 1'b1};
    vecs[3] = '{1'b1, 32'h0000_0008, 1'b1, 1'b1, 2'b11, 1'b1};
    vecs[4] = '{1'b1, 32'h0000_0008, 1'b0, 1'b1, 2'b11, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_0008, 1'b0, 1'b1, 2'b10, 1'b1};
    vecs[6] = '{1'b1, 32'h0000_0008, 1'b0, 1'b1, 2'b01, 1'b1};
    vecs[7] = '{1'b1, 32'h0000_0008, 1'b0, 1'b1, 2'b00, 1'b1};
    vecs[8] = '{1'b0, 32'h0000_0008, 1'b0, 1'b1, 2'b00, 1'b1};
    vecs[9] = '{1'b0, 32'h0000_0008, 1'b0, 1'b0, 2'b00, 1'b1};

    fpc[0] = 32'h10; ftk[0] = 1'b1;
    fpc[1] = 32'h14; ftk[1] = 1'b1;
    fpc[2] = 32'h10; ftk[2] = 1'b1;
    fpc[3] = 32'h18; ftk[3] = 1'b0;
    fpc[4] = 32'h14; ftk[4] = 1'b1;

    // Reset state, with an update offered
    repeat (2) @(negedge clk_i);
    put_upd(32'h8, 1'b1);
    #1;
    chk("rst_we", tbl_we_o, 1'b0);
    chk("rst_pred", pred_enable_o, 1'b0);
    chk("rst_busy", busy_o, 1'b1);
    chk("rst_ready", upd_ready_o, 1'b0);
    upd_valid_i = 1'b0;
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    do_sweep("init");

    // Table-driven saturating updates
    for (int v = 0; v < 10; v++) begin
      @(negedge clk_i);
      upd_valid_i = vecs[v].valid;
      upd_pc_i    = vecs[v].pc;
      upd_taken_i = vecs[v].taken;
      #1;
      chk($sformatf("vec%0d_we", v), tbl_we_o, vecs[v].exp_we);
      chk($sformatf("vec%0d_ready", v), upd_ready_o, vecs[v].exp_ready);
      if (vecs[v].exp_we) begin
        chk($sformatf("vec%0d_addr", v), tbl_wr_addr_o, 4'd2);
        chk($sformatf("vec%0d_data", v), tbl_wr_data_o, vecs[v].exp_data);
      end
    end

    // Fill the FIFO during a flush sweep; fifth update must be held
    @(negedge clk_i);
    idle_inputs();
    flush_i = 1'b1;
    #1;
    chk("fl_ready_lo", upd_ready_o, 1'b0);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk_i);
      flush_i = 1'b0;
      if (c < 5) put_upd(fpc[c], ftk[c]);
      #1;
      chk($sformatf("full_ready%0d", c), upd_ready_o, (c < 4) ? 1'b1 : 1'b0);
      chk($sformatf("full_swaddr%0d", c), tbl_wr_addr_o, c);
      chk($sformatf("full_pred%0d", c), pred_enable_o, 1'b0);
    end
    @(negedge clk_i); #1;
    chk("drain0_ready", upd_ready_o, 1'b0);
    chk("drain0_addr", tbl_wr_addr_o, 4'd4);
    chk("drain0_data", tbl_wr_data_o, 2'b01);
    chk("drain0_pred", pred_enable_o, 1'b1);
    @(negedge clk_i); #1;
    chk("drain1_ready", upd_ready_o, 1'b1);
    chk("drain1_addr", tbl_wr_addr_o, 4'd5);
    chk("drain1_data", tbl_wr_data_o, 2'b01);
    @(negedge clk_i); idle_inputs(); #1;
    chk("drain2_addr", tbl_wr_addr_o, 4'd4);
    chk("drain2_data", tbl_wr_data_o, 2'b10);
    @(negedge clk_i); #1;
    chk("drain3_addr", tbl_wr_addr_o, 4'd6);
    chk("drain3_data", tbl_wr_data_o, 2'b00);
    chk("drain3_we", tbl_we_o, 1'b1);
    @(negedge clk_i); #1;
    chk("drain4_addr", tbl_wr_addr_o, 4'd5);
    chk("drain4_data", tbl_wr_data_o, 2'b10);
    @(negedge clk_i); #1;
    chk("drain5_we", tbl_we_o, 1'b0);
    chk("drain5_busy", busy_o, 1'b0);

    // Flush at sweep address 9 with two updates queued and one offered
    @(negedge clk_i);
    flush_i = 1'b1;
    #1;
    nz_snap = nz_writes;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      idle_inputs();
      if (c == 0) put_upd(32'h1C, 1'b1);
      if (c == 1) put_upd(32'h20, 1'b1);
      if (c == 9) begin
        put_upd(32'h24, 1'b1);
        flush_i = 1'b1;
      end
      #1;
      chk($sformatf("mid_addr%0d", c), tbl_wr_addr_o, c);
    end
    chk("mid_flush_ready", upd_ready_o, 1'b0);
    chk("mid_flush_we", tbl_we_o, 1'b1);
    do_sweep("reflush");
    @(negedge clk_i); #1;
    chk("reflush_we_after", tbl_we_o, 1'b0);
    chk("reflush_no_upd", nz_writes, nz_snap);
    chk("reflush_bht4", bht[4], 2'b00);

    // Async reset with an update about to be written
    @(negedge clk_i);
    put_upd(32'h0C, 1'b1);
    #1;
    @(negedge clk_i);
    idle_inputs();
    #1;
    chk("pre_rst_we", tbl_we_o, 1'b1);
    chk("pre_rst_addr", tbl_wr_addr_o, 4'd3);
    chk("pre_rst_data", tbl_wr_data_o, 2'b01);
    nz_snap = nz_writes;
    #1 rst_i = 1'b0;
    #1;
    chk("async_rst_we", tbl_we_o, 1'b0);
    chk("async_rst_pred", pred_enable_o, 1'b0);
    chk("async_rst_busy", busy_o, 1'b1);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    do_sweep("rst2");
    chk("rst2_lost_upd", nz_writes, nz_snap);
    chk("rst2_bht3", bht[3], 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bht_update_ctrl.md
Name: bht_update_ctrl

Overview:
Controller that owns the write port of the 2-bit branch history table (BHT). It clears the table after reset and on flush with a one-entry-per-cycle sweep. It buffers resolved-branch updates from EX in a small FIFO and applies them as saturating read-modify-write operations. It also tells IF when predictions are valid, and sits between the EX branch-resolution logic and the BHT storage array.

Parameters:
N, 10, log2 of BHT entries; table index = pc[N+1:2]
FIFO_DEPTH, 4, update FIFO entries (power of two, >= 2)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous, active-low reset
upd_valid_i  input  1  EX presents a resolved conditional branch
upd_pc_i  input  32  PC of the resolved branch
upd_taken_i  input  1  actual outcome (1 = taken)
upd_ready_o  output  1  FIFO accepts the update this cycle
flush_i  input  1  one-cycle request to clear the whole table
tbl_rd_addr_o  output  N  combinational read address into the BHT
tbl_rd_data_i  input  2  combinational read data from the BHT
tbl_we_o  output  1  BHT write enable (table writes at clk_i rising edge)
tbl_wr_addr_o  output  N  BHT write address
tbl_wr_data_o  output  2  BHT write data
pred_enable_o  output  1  1 = BHT contents valid, IF may use predictions
busy_o  output  1  sweep in progress or updates pending

Behaviour:
- Counter encoding: 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken.
- States: INIT, RUN, FLUSH. INIT and FLUSH behave identically as sweeps.
- Reset (rst_i low): state = INIT, sweep counter = 0, FIFO empty.
- While rst_i is low: tbl_we_o = 0, pred_enable_o = 0, busy_o = 1, upd_ready_o = 0.
- Sweep: each cycle tbl_we_o = 1, tbl_wr_addr_o = sweep counter, tbl_wr_data_o = 00, then the counter increments.
  - The write at address 2**N-1 is the last sweep cycle. The next cycle is RUN.
  - A sweep takes exactly 2**N cycles.
- RUN with the FIFO not empty, all in the same cycle:
  - tbl_rd_addr_o = head.pc[N+1:2], and tbl_wr_addr_o is the same address.
  - tbl_wr_data_o = saturating increment of tbl_rd_data_i if head.taken, otherwise saturating decrement.
  - tbl_we_o = 1 and the head is popped.
  - 11 + taken stays 11. 00 + not-taken stays 00. No wrap.
- RUN with the FIFO empty: tbl_we_o = 0. Write address and data are don't-care, but drive 0.
- Throughput is one update per cycle. Back-to-back updates to the same index are correct because the write lands at the edge and the next read sees it. No forwarding is needed.
- Push: when upd_valid_i && upd_ready_o, store {upd_pc_i[N+1:2], upd_taken_i}.
  - upd_ready_o = !full && !flush_i.
  - Updates are accepted during sweeps and applied after the sweep completes.
  - Push and pop in the same cycle is allowed when not full. Occupancy is unchanged.
- Full FIFO: upd_ready_o = 0. The producer holds the request. Nothing is dropped.
- flush_i in any state: the next state is FLUSH, the sweep counter is 0, and the FIFO is emptied (queued updates are discarded).
  - The update offered in the same cycle is not accepted.
  - flush_i during a sweep restarts the sweep from 0.
  - No table write from the FIFO occurs in the flush cycle. A sweep write in that cycle is permitted.
- pred_enable_o = (state == RUN), registered state decode. It is 0 for the entire sweep.
- busy_o = (state != RUN) || FIFO not empty.
- A reset asserted mid-sweep or mid-update immediately returns to INIT and clears the FIFO.

Decomposition:
- Package bp_pkg: counter encodings (SNT/WNT/WT/ST), state enum (INIT/RUN/FLUSH), and a saturating counter update function.
- One sub-module, bp_upd_fifo: a synchronous FIFO, parameterised on width and depth, with push/pop/clear, full/empty flags, and async active-low reset.

Test Plan:
- Reset release with N=4 -> tbl_we_o = 1 for 16 consecutive cycles, addresses 0..15, data 00. pred_enable_o rises the cycle after address 15. busy_o falls with it when the FIFO is empty.
- In RUN, 4 taken updates to pc 0x0000_0008 on consecutive cycles -> writes to index 2 with data 01, 10, 11, 11 (saturation). Then 4 not-taken -> 10, 01, 00, 00.
- Hold the consumer inside a sweep (FLUSH) and push 5 updates with FIFO_DEPTH=4 -> upd_ready_o goes low after 4 accepts. The 5th is held. All 5 are applied in order after the sweep.
- flush_i asserted together with upd_valid_i while 2 updates are queued -> upd_ready_o = 0 that cycle. The FIFO is emptied. A 16-cycle sweep follows. No queued update is ever written.
- flush_i mid-sweep at address 9 -> the sweep restarts at 0, for a total of 16 more writes before pred_enable_o = 1.
- Drive rst_i low during RUN with a pending update -> tbl_we_o and pred_enable_o go to 0 immediately (async). After release there is a full INIT sweep and the pending update is lost.
